// File: rtl/clock_pkg.sv
// Shared encodings for the clock front-end and the calendar counter chain.
// Field select codes, increment bit positions and counter width helper.
package clock_pkg;

    localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;

    typedef logic [2:0] field_t;

    localparam field_t FLD_RUN   = 3'd0;
    localparam field_t FLD_YEAR  = 3'd1;
    localparam field_t FLD_MONTH = 3'd2;
    localparam field_t FLD_DAY   = 3'd3;
    localparam field_t FLD_HOUR  = 3'd4;
    localparam field_t FLD_MIN   = 3'd5;
    localparam field_t FLD_SEC   = 3'd6;

    localparam int INC_SEC   = 0;
    localparam int INC_MIN   = 1;
    localparam int INC_HOUR  = 2;
    localparam int INC_DAY   = 3;
    localparam int INC_MONTH = 4;
    localparam int INC_YEAR  = 5;

    // width of a counter that must hold n distinct values
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button inputs and set-mode outputs between time_set_ctrl and its consumer.
// master = time_set_ctrl side, slave = clock_top_module / board side.
interface time_set_ctrl_if;
    import clock_pkg::*;

    logic       btn_mode_raw;
    logic       btn_inc_raw;
    logic       tick_1hz;
    logic       set_mode;
    field_t     field_sel;
    logic [5:0] inc_pulse;
    logic       blink_on;

    modport master (
        input  btn_mode_raw,
        input  btn_inc_raw,
        output tick_1hz,
        output set_mode,
        output field_sel,
        output inc_pulse,
        output blink_on
    );

    modport slave (
        output btn_mode_raw,
        output btn_inc_raw,
        input  tick_1hz,
        input  set_mode,
        input  field_sel,
        input  inc_pulse,
        input  blink_on
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counting debouncer and registered press pulse.
// The debounced level is exported only when AUTO_REPEAT_EN is defined.
module button_debounce
    import clock_pkg::*;
#(
    parameter int DB_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
`ifdef AUTO_REPEAT_EN
    output logic level,
`endif
    output logic press
);

    localparam int W = cnt_w(DB_CYC);
    localparam logic [W-1:0] TC = W'(DB_CYC - 1);

    logic         s1;
    logic         s2;
    logic         lvl;
    logic         lvl_q;
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            press <= lvl & ~lvl_q;
            // any cycle agreeing with the level restarts the count
            if (s2 != lvl) begin
                if (cnt == TC) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    assign level = lvl;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set front end: 1 Hz prescaler, button debounce, field-select FSM, blink.
// Optional INC auto-repeat is built when AUTO_REPEAT_EN is defined.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = CLK_FREQ_HZ_DEFAULT,
    parameter int DEBOUNCE_MS     = 20,
    parameter int BLINK_HZ        = 2
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_HZ       = 8
`endif
) (
    input  logic            built_in_clk,
    input  logic            glob_rst,
    time_set_ctrl_if.master bus
);

    localparam int DB_CYC = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int HALF   = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int PS_W   = cnt_w(CLK_FREQ_HZ);
    localparam int BL_W   = cnt_w(HALF);
    localparam logic [PS_W-1:0] PS_TC = PS_W'(CLK_FREQ_HZ - 1);
    localparam logic [BL_W-1:0] BL_TC = BL_W'(HALF - 1);

    logic            mode_press;
    logic            inc_press;
    logic            rep_fire;
    logic            fire;
    logic            set_mode;
    logic [5:0]      inc_mask;
    logic [5:0]      inc_q;
    logic            blink_q;
    logic [BL_W-1:0] bl_cnt;
    logic [PS_W-1:0] ps_cnt;
    field_t          state;
    field_t          state_nx;

`ifdef AUTO_REPEAT_EN
    logic mode_level;
    logic inc_level;
`endif

    button_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
        .clk   (built_in_clk),
        .rst   (glob_rst),
        .raw   (bus.btn_mode_raw),
`ifdef AUTO_REPEAT_EN
        .level (mode_level),
`endif
        .press (mode_press)
    );

    button_debounce #(.DB_CYC(DB_CYC)) u_db_inc (
        .clk   (built_in_clk),
        .rst   (glob_rst),
        .raw   (bus.btn_inc_raw),
`ifdef AUTO_REPEAT_EN
        .level (inc_level),
`endif
        .press (inc_press)
    );

    always_ff @(posedge built_in_clk) begin
        if (glob_rst) state <= FLD_RUN;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (mode_press) begin
            unique case (state)
                FLD_RUN:   state_nx = FLD_YEAR;
                FLD_YEAR:  state_nx = FLD_MONTH;
                FLD_MONTH: state_nx = FLD_DAY;
                FLD_DAY:   state_nx = FLD_HOUR;
                FLD_HOUR:  state_nx = FLD_MIN;
                FLD_MIN:   state_nx = FLD_SEC;
                default:   state_nx = FLD_RUN;
            endcase
        end
    end

    always_comb begin
        set_mode = (state != FLD_RUN);
        inc_mask = '0;
        unique case (1'b1)
            (state == FLD_YEAR):  inc_mask[INC_YEAR]  = 1'b1;
            (state == FLD_MONTH): inc_mask[INC_MONTH] = 1'b1;
            (state == FLD_DAY):   inc_mask[INC_DAY]   = 1'b1;
            (state == FLD_HOUR):  inc_mask[INC_HOUR]  = 1'b1;
            (state == FLD_MIN):   inc_mask[INC_MIN]   = 1'b1;
            (state == FLD_SEC):   inc_mask[INC_SEC]   = 1'b1;
            default:              inc_mask = '0;
        endcase
    end

    // MODE wins over a coincident INC; RUN ignores INC
    assign fire = (inc_press | rep_fire) & ~mode_press & set_mode;

    always_ff @(posedge built_in_clk) begin
        if (glob_rst) inc_q <= '0;
        else          inc_q <= fire ? inc_mask : '0;
    end

    always_ff @(posedge built_in_clk) begin
        if (glob_rst || set_mode)  ps_cnt <= '0;
        else if (ps_cnt == PS_TC)  ps_cnt <= '0;
        else                       ps_cnt <= ps_cnt + 1'b1;
    end

    always_ff @(posedge built_in_clk) begin
        if (glob_rst || mode_press || fire || !set_mode) begin
            bl_cnt  <= '0;
            blink_q <= 1'b1;
        end else if (bl_cnt == BL_TC) begin
            bl_cnt  <= '0;
            blink_q <= ~blink_q;
        end else begin
            bl_cnt  <= bl_cnt + 1'b1;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_DLY = CLK_FREQ_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int REP_PER = CLK_FREQ_HZ / REPEAT_HZ;
    localparam int RP_W    = cnt_w((REP_DLY > REP_PER) ? REP_DLY : REP_PER);
    localparam logic [RP_W-1:0] DLY_TC = RP_W'(REP_DLY - 1);
    localparam logic [RP_W-1:0] PER_TC = RP_W'(REP_PER - 1);

    logic            rep_on;
    logic            rep_phase;
    logic [RP_W-1:0] rep_cnt;
    logic [RP_W-1:0] rep_lim;

    assign rep_lim  = rep_phase ? PER_TC : DLY_TC;
    assign rep_fire = rep_on & (rep_cnt == rep_lim);

    // first repeat after the hold delay, then at the repeat period
    always_ff @(posedge built_in_clk) begin
        if (glob_rst || !set_mode || mode_press || mode_level || !inc_level) begin
            rep_on    <= 1'b0;
            rep_phase <= 1'b0;
            rep_cnt   <= '0;
        end else if (inc_press) begin
            rep_on    <= 1'b1;
            rep_phase <= 1'b0;
            rep_cnt   <= '0;
        end else if (rep_on) begin
            if (rep_cnt == rep_lim) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign bus.tick_1hz  = (ps_cnt == PS_TC) & ~set_mode;
    assign bus.set_mode  = set_mode;
    assign bus.field_sel = state;
    assign bus.inc_pulse = inc_q;
    assign bus.blink_on  = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl at sim scale (1 kHz clock, 2-cycle debounce).
// Per-cycle comparison against a behavioural model plus directed checks.
module tb_time_set_ctrl;

    localparam int TB_CLK = 1000;
    localparam int DB     = 2;
    localparam int HP     = 10;

    logic clk;
    logic rst;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .CLK_FREQ_HZ (TB_CLK),
        .DEBOUNCE_MS (2),
        .BLINK_HZ    (50)
    ) dut (
        .built_in_clk (clk),
        .glob_rst     (rst),
        .bus          (bus)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit chk_en = 0;

    bit mh[$];
    bit ih[$];
    bit m_lvl, i_lvl, m_rose, i_rose, m_prs, i_prs;
    int e_field, e_inc, run_age, blink_age;

    int tick_q[$];
    int inc_q[$];
    int run_entry = 0;
    int prev_field = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // level flips when the DB samples seen by the debouncer all disagree
    function automatic bit flip(input bit h[$], input bit lvl);
        for (int i = 0; i < DB; i++)
            if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit mp, ip, fire;
        int of;
        if (rst) begin
            mh.delete();
            ih.delete();
            for (int i = 0; i <= DB; i++) begin
                mh.push_back(1'b0);
                ih.push_back(1'b0);
            end
            {m_lvl, i_lvl, m_rose, i_rose, m_prs, i_prs} = '0;
            e_field = 0; e_inc = 0; run_age = 0; blink_age = 0; cyc = 0;
        end else begin
            cyc++;
            mp = m_prs;
            ip = i_prs;
            fire = ip && !mp && e_field != 0;
            e_inc = fire ? (1 << (6 - e_field)) : 0;
            of = e_field;
            if (mp) e_field = (e_field + 1) % 7;
            run_age = (of != 0) ? 0 : run_age + 1;
            blink_age = (mp || fire) ? 0 : blink_age + 1;
            m_prs = m_rose;
            i_prs = i_rose;
            m_rose = 1'b0;
            i_rose = 1'b0;
            if (flip(mh, m_lvl)) begin m_lvl = !m_lvl; m_rose = m_lvl; end
            if (flip(ih, i_lvl)) begin i_lvl = !i_lvl; i_rose = i_lvl; end
            mh.push_back(bus.btn_mode_raw);
            ih.push_back(bus.btn_inc_raw);
            void'(mh.pop_front());
            void'(ih.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tick_1hz", 32'(bus.tick_1hz),
                  32'(e_field == 0 && run_age % TB_CLK == TB_CLK - 1));
            check("set_mode", 32'(bus.set_mode), 32'(e_field != 0));
            check("field_sel", 32'(bus.field_sel), 32'(e_field));
            check("inc_pulse", 32'(bus.inc_pulse), 32'(e_inc));
            check("blink_on", 32'(bus.blink_on),
                  32'(e_field == 0 || (blink_age / HP) % 2 == 0));
            if (bus.tick_1hz === 1'b1) tick_q.push_back(cyc);
            if (bus.inc_pulse != 6'd0) inc_q.push_back(int'(bus.inc_pulse));
            if (prev_field != 0 && bus.field_sel == 3'd0) run_entry = cyc;
            prev_field = int'(bus.field_sel);
        end
    end

    task automatic press(input bit m, input bit i, input int hold);
        @(negedge clk);
        bus.btn_mode_raw = m;
        bus.btn_inc_raw  = i;
        repeat (hold) @(negedge clk);
        bus.btn_mode_raw = 1'b0;
        bus.btn_inc_raw  = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic wait_tick(input string nm, input int want, input int base);
        int n = tick_q.size();
        int t = 0;
        while (tick_q.size() == n && t < 1100) begin
            @(negedge clk);
            t++;
        end
        if (tick_q.size() == n) check({nm, "_timeout"}, 32'd0, 32'd1);
        else check(nm, 32'(tick_q[n] - base), 32'(want));
    endtask

    initial begin
        int fseq [6] = '{2, 3, 4, 5, 6, 0};
        int n;
        rst = 1'b1;
        bus.btn_mode_raw = 1'b0;
        bus.btn_inc_raw  = 1'b0;
        @(negedge clk);
        chk_en = 1;
        check("rst_field", 32'(bus.field_sel), 32'd0);
        check("rst_blink", 32'(bus.blink_on), 32'd1);
        check("rst_inc", 32'(bus.inc_pulse), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (3000) @(negedge clk);
        check("tick_count", 32'(tick_q.size()), 32'd3);
        if (tick_q.size() == 3) begin
            check("tick0", 32'(tick_q[0]), 32'd999);
            check("tick1", 32'(tick_q[1]), 32'd1999);
            check("tick2", 32'(tick_q[2]), 32'd2999);
        end
        check("run_field", 32'(bus.field_sel), 32'd0);
        check("run_blink", 32'(bus.blink_on), 32'd1);

        press(1'b1, 1'b0, 1);
        check("glitch_field", 32'(bus.field_sel), 32'd0);
        press(1'b1, 1'b0, 10);
        check("mode1_field", 32'(bus.field_sel), 32'd1);
        check("mode1_set", 32'(bus.set_mode), 32'd1);
        n = tick_q.size();
        repeat (1100) @(negedge clk);
        check("set_no_tick", 32'(tick_q.size()), 32'(n));

        for (int k = 0; k < 6; k++) begin
            press(1'b1, 1'b0, 10);
            check($sformatf("mode_seq%0d", k), 32'(bus.field_sel),
                  32'(fseq[k]));
        end
        check("exit_set", 32'(bus.set_mode), 32'd0);
        wait_tick("exit_tick", 999, run_entry);

        repeat (5) press(1'b1, 1'b0, 10);
        check("min_field", 32'(bus.field_sel), 32'd5);
        n = inc_q.size();
        repeat (3) press(1'b0, 1'b1, 10);
        check("min_inc_cnt", 32'(inc_q.size() - n), 32'd3);
        for (int k = n; k < inc_q.size(); k++)
            check("min_inc_val", 32'(inc_q[k]), 32'b000010);

        repeat (3) press(1'b1, 1'b0, 10);
        check("year_field", 32'(bus.field_sel), 32'd1);
        n = inc_q.size();
        press(1'b1, 1'b1, 10);
        check("both_field", 32'(bus.field_sel), 32'd2);
        check("both_no_inc", 32'(inc_q.size()), 32'(n));

        repeat (2) press(1'b1, 1'b0, 10);
        check("hour_field", 32'(bus.field_sel), 32'd4);
        bus.btn_inc_raw = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = inc_q.size();
        check("mrst_field", 32'(bus.field_sel), 32'd0);
        check("mrst_set", 32'(bus.set_mode), 32'd0);
        check("mrst_blink", 32'(bus.blink_on), 32'd1);
        check("mrst_inc", 32'(bus.inc_pulse), 32'd0);
        wait_tick("mrst_tick", 999, 0);
        check("mrst_inc_ignored", 32'(inc_q.size()), 32'(n));
        bus.btn_inc_raw = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
